i2c_slave: RTL and testbench

I2C target (responder) for the same bus that the team's i2c_master drives. It decodes START/STOP, matches a 7-bit device ID, and accepts a register address byte followed by write data bytes. On a read it returns register data with auto-increment. SCL/SDA are oversampled on the system clock; the register storage sits outside the block on a simple strobe interface.

---
 rtl/i2c_slave.sv | 217 +++++++++++++++++++++
 tb/tb_i2c_slave.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C target: START/STOP decode, 7-bit ID match, register pointer, write data and auto-increment read.
// Latency: ~SYNC_STAGES+2 clocks from bus pins to action; no backpressure (never stretches SCL).
module i2c_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [6:0]        dev_id,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        wr_data,
    output logic              wr_en,
    output logic              rd_en,
    input  logic [7:0]        rd_data,
    output logic              busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, MACK, RLOAD, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic scl_f_q, sda_f_q, scl_dly_q, sda_dly_q;

    // Filtered level only moves once every synchronizer stage agrees, so short glitches never reach it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            if (&scl_sync_q)       scl_f_q <= 1'b1;
            else if (~|scl_sync_q) scl_f_q <= 1'b0;
            if (&sda_sync_q)       sda_f_q <= 1'b1;
            else if (~|sda_sync_q) sda_f_q <= 1'b0;
            scl_dly_q  <= scl_f_q;
            sda_dly_q  <= sda_f_q;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_f_q & ~scl_dly_q;
    assign scl_fall  = ~scl_f_q & scl_dly_q;
    assign start_det = scl_f_q & scl_dly_q & sda_dly_q & ~sda_f_q;
    assign stop_det  = scl_f_q & scl_dly_q & ~sda_dly_q & sda_f_q;

    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        sh_q, sh_d;
    logic [7:0]        tx_q, tx_d, wr_data_q, wr_data_d, rx_byte;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic              sda_oe_q, sda_oe_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic              busy_q, busy_d, rw_q, rw_d, drv_q, drv_d;

    assign rx_byte = {sh_q, sda_f_q};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd7;
            sh_q       <= '0;
            tx_q       <= '0;
            wr_data_q  <= '0;
            reg_addr_q <= '0;
            sda_oe_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            drv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            tx_q       <= tx_d;
            wr_data_q  <= wr_data_d;
            reg_addr_q <= reg_addr_d;
            sda_oe_q   <= sda_oe_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            drv_q      <= drv_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sh_d       = sh_q;
        tx_d       = tx_q;
        wr_data_d  = wr_data_q;
        reg_addr_d = reg_addr_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rw_d       = rw_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        drv_d      = 1'b0;
        // rd_data is valid the clock after rd_en; the first read byte drives its MSB as soon as it lands.
        if (rd_en_q) begin
            tx_d = rd_data;
            if (drv_q && state_q == RDATA) sda_oe_d = ~rd_data[7];
        end
        if (stop_det) begin
            state_d   = IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 3'd7;
        end else if (start_det) begin
            state_d   = ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd7;
        end else begin
            case (state_q)
                ADDR, REG, WDATA: begin
                    if (scl_rise) begin
                        if (bit_cnt_q == 3'd0) begin
                            bit_cnt_d = 3'd7;
                            if (state_q == ADDR) begin
                                if (rx_byte[7:1] == dev_id) begin
                                    rw_d    = rx_byte[0];
                                    busy_d  = 1'b1;
                                    state_d = ADDR_ACK;
                                end else begin
                                    busy_d  = 1'b0;
                                    state_d = IGNORE;
                                end
                            end else if (state_q == REG) begin
                                reg_addr_d = ADDR_W'(rx_byte);
                                state_d    = REG_ACK;
                            end else begin
                                wr_data_d = rx_byte;
                                wr_en_d   = 1'b1;
                                state_d   = WDATA_ACK;
                            end
                        end else begin
                            sh_d      = {sh_q[5:0], sda_f_q};
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end
                ADDR_ACK, REG_ACK, WDATA_ACK: begin
                    // First fall asserts the ACK, second fall ends the ACK clock.
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            if (state_q == ADDR_ACK) begin
                                if (rw_q) begin
                                    rd_en_d   = 1'b1;
                                    drv_d     = 1'b1;
                                    bit_cnt_d = 3'd7;
                                    state_d   = RDATA;
                                end else begin
                                    state_d = REG;
                                end
                            end else if (state_q == REG_ACK) begin
                                state_d = WDATA;
                            end else begin
                                reg_addr_d = reg_addr_q + ADDR_W'(1);
                                state_d    = WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            state_d  = MACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                            sda_oe_d  = ~tx_q[6];
                            tx_d      = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                MACK: begin
                    if (scl_rise) begin
                        if (!sda_f_q) begin
                            reg_addr_d = reg_addr_q + ADDR_W'(1);
                            rd_en_d    = 1'b1;
                            state_d    = RLOAD;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IGNORE;
                        end
                    end
                end
                RLOAD: begin
                    if (scl_fall) begin
                        sda_oe_d  = ~tx_q[7];
                        bit_cnt_d = 3'd7;
                        state_d   = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign reg_addr = reg_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_en    = wr_en_q;
    assign rd_en    = rd_en_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master driving i2c_slave; expected bus responses and writes go through scoreboard queues.
module tb_i2c_slave;
    localparam int Q = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] dev_id = 7'h42;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_in, sda_oe, wr_en, rd_en, busy;
    logic [7:0] reg_addr, wr_data, rd_data;
    logic [7:0] mem [256];

    assign sda_in  = sda_m & ~sda_oe;
    assign rd_data = mem[reg_addr];

    i2c_slave #(.SYNC_STAGES(2), .ADDR_W(8)) dut (
        .clock(clock), .reset(reset), .dev_id(dev_id), .scl_in(scl), .sda_in(sda_in),
        .sda_oe(sda_oe), .reg_addr(reg_addr), .wr_data(wr_data), .wr_en(wr_en),
        .rd_en(rd_en), .rd_data(rd_data), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, oe_hi_cnt = 0;
    logic [15:0] exp_wr_q [$];
    logic [7:0]  exp_q [$];
    logic [7:0]  act_q [$];
    string       tag_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares write strobes and sampled bus responses as the DUT presents them.
    initial begin
        logic [15:0] e;
        logic [7:0]  ev, av;
        string       t;
        forever begin
            @(negedge clock);
            if (sda_oe) oe_hi_cnt++;
            if (rd_en) rd_cnt++;
            if (wr_en && rd_en) both_cnt++;
            if (wr_en) begin
                wr_cnt++;
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected actual=%0h/%0h required=none", reg_addr, wr_data);
                end else begin
                    e = exp_wr_q.pop_front();
                    chk("wr_addr", 32'(reg_addr), 32'(e[15:8]));
                    chk("wr_data", 32'(wr_data), 32'(e[7:0]));
                end
            end
            while (act_q.size() > 0 && exp_q.size() > 0) begin
                av = act_q.pop_front();
                ev = exp_q.pop_front();
                t  = tag_q.pop_front();
                chk(t, 32'(av), 32'(ev));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic start_c();
        sda_m = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        sda_m = 1'b0; tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic stop_c();
        sda_m = 1'b0; tick(Q);
        scl = 1'b1;   tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic put_bit(input logic b, input logic glitch);
        sda_m = b; tick(Q);
        scl = 1'b1; tick(Q);
        if (glitch) begin
            sda_m = ~b; tick(1);
            sda_m = b;  tick(Q - 1);
        end else begin
            tick(Q);
        end
        scl = 1'b0; tick(Q);
    endtask

    task automatic get_bit(output logic r);
        sda_m = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        r = sda_in;   tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag,
                             input logic [7:0] gmask);
        logic r;
        exp_q.push_back({7'd0, exp_ack});
        tag_q.push_back(tag);
        for (int i = 7; i >= 0; i--) put_bit(b[i], gmask[i]);
        get_bit(r);
        act_q.push_back({7'd0, r});
    endtask

    task automatic recv_byte(input logic [7:0] exp, input logic mack, input string tag);
        logic       r;
        logic [7:0] v;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        for (int i = 7; i >= 0; i--) begin
            get_bit(r);
            v[i] = r;
        end
        act_q.push_back(v);
        put_bit(mack, 1'b0);
    endtask

    initial begin
        int w0, r0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h20] = 8'h3C;
        mem[8'h21] = 8'h7E;

        tick(3);
        chk("rst_sda_oe", 32'(sda_oe), 0);
        chk("rst_reg_addr", 32'(reg_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_state", 32'(dut.state_q), 0);
        chk("rst_bit_cnt", 32'(dut.bit_cnt_q), 7);
        reset = 1'b0;
        tick(Q);

        // Basic write: ID, pointer 0x10, data 0xA5.
        start_c();
        send_byte(8'h84, 1'b0, "wr_id_ack", 8'h00);
        chk("wr_busy", 32'(busy), 1);
        send_byte(8'h10, 1'b0, "wr_reg_ack", 8'h00);
        exp_wr_q.push_back({8'h10, 8'hA5});
        send_byte(8'hA5, 1'b0, "wr_dat_ack", 8'h00);
        stop_c();
        tick(Q);
        chk("wr_busy_stop", 32'(busy), 0);
        chk("wr_ptr_inc", 32'(reg_addr), 32'h11);

        // Wrong ID: no ACK, SDA never pulled.
        w0 = wr_cnt; r0 = rd_cnt; oe_hi_cnt = 0;
        start_c();
        send_byte(8'h86, 1'b1, "bad_id_nack", 8'h00);
        chk("bad_busy", 32'(busy), 0);
        send_byte(8'h55, 1'b1, "bad_dat_nack", 8'h00);
        stop_c();
        tick(Q);
        chk("bad_oe_cycles", 32'(oe_hi_cnt), 0);
        chk("bad_wr_cnt", 32'(wr_cnt - w0), 0);
        chk("bad_rd_cnt", 32'(rd_cnt - r0), 0);

        // Pointer write, repeated START, two-byte read (ACK then NACK).
        r0 = rd_cnt;
        start_c();
        send_byte(8'h84, 1'b0, "rd_id_ack", 8'h00);
        send_byte(8'h20, 1'b0, "rd_reg_ack", 8'h00);
        start_c();
        send_byte(8'h85, 1'b0, "rd_idr_ack", 8'h00);
        recv_byte(8'h3C, 1'b0, "rd_byte0");
        recv_byte(8'h7E, 1'b1, "rd_byte1");
        tick(2);
        chk("rd_ptr_end", 32'(reg_addr), 32'h21);
        chk("rd_sda_rel", 32'(sda_oe), 0);
        chk("rd_busy_nack", 32'(busy), 0);
        chk("rd_en_cnt", 32'(rd_cnt - r0), 2);
        stop_c();
        tick(Q);

        // Pointer wrap across consecutive writes.
        start_c();
        send_byte(8'h84, 1'b0, "wrap_id_ack", 8'h00);
        send_byte(8'hFF, 1'b0, "wrap_reg_ack", 8'h00);
        exp_wr_q.push_back({8'hFF, 8'h11});
        send_byte(8'h11, 1'b0, "wrap_d0_ack", 8'h00);
        exp_wr_q.push_back({8'h00, 8'h22});
        send_byte(8'h22, 1'b0, "wrap_d1_ack", 8'h00);
        stop_c();
        tick(Q);
        chk("wrap_ptr", 32'(reg_addr), 32'h01);

        // STOP after four data bits: partial byte discarded.
        w0 = wr_cnt;
        start_c();
        send_byte(8'h84, 1'b0, "part_id_ack", 8'h00);
        send_byte(8'h30, 1'b0, "part_reg_ack", 8'h00);
        for (int i = 0; i < 4; i++) put_bit(1'b1, 1'b0);
        stop_c();
        tick(Q);
        chk("part_wr_cnt", 32'(wr_cnt - w0), 0);
        chk("part_ptr", 32'(reg_addr), 32'h30);
        chk("part_state", 32'(dut.state_q), 0);
        chk("part_busy", 32'(busy), 0);

        // Glitches on idle bus, then on SDA while SCL is high inside a frame.
        sda_m = 1'b0; tick(1);
        sda_m = 1'b1; tick(Q);
        chk("glitch_idle_state", 32'(dut.state_q), 0);
        chk("glitch_idle_busy", 32'(busy), 0);
        start_c();
        send_byte(8'h84, 1'b0, "gl_id_ack", 8'h00);
        send_byte(8'h40, 1'b0, "gl_reg_ack", 8'hC0);
        chk("glitch_busy", 32'(busy), 1);
        exp_wr_q.push_back({8'h40, 8'h99});
        send_byte(8'h99, 1'b0, "gl_dat_ack", 8'h00);
        stop_c();
        tick(Q);

        // Reset while the ACK is being driven releases SDA at once.
        start_c();
        for (int i = 7; i >= 0; i--) put_bit(i == 7 || i == 2, 1'b0);
        sda_m = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        chk("ack_driven", 32'(sda_oe), 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_oe", 32'(sda_oe), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        tick(2);
        reset = 1'b0;
        tick(2 * Q);

        chk("wr_q_empty", 32'(exp_wr_q.size()), 0);
        chk("bus_q_empty", 32'(exp_q.size()), 0);
        chk("wr_rd_overlap", 32'(both_cnt), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
